// File: rtl/shot_acc_buf_pkg.sv
// Shared types and helpers for the shot accumulation buffer.
// Holds the sequencer state encoding, flush length and the saturating adder.
package shot_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    FLUSH
  } state_t;

  localparam int unsigned FLUSH_CYCLES = 2;

  // Wide enough for any accumulator width this block is built with.
  localparam int unsigned SAT_W = 64;
  typedef logic signed [SAT_W-1:0] sat_t;

  // Signed add clamped to the range of a w-bit two's complement word.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] maxv;
    logic signed [SAT_W:0] minv;
    sum  = (SAT_W+1)'(a) + (SAT_W+1)'(b);
    maxv = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
    minv = ~maxv;
    if (sum > maxv) begin
      return maxv[SAT_W-1:0];
    end else if (sum < minv) begin
      return minv[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/shot_acc_buf_if.sv
// DSP-side run control, ADC stream, status and host readback bundle.
// master = DSP register bank / ADC source, slave = shot_acc_buf.
interface shot_acc_buf_if #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 10,
  parameter int unsigned ACCW   = 32,
  parameter int unsigned NSHOTW = 16
);

  logic                 stb_start;
  logic [NSHOTW-1:0]    nshot;
  logic [AW:0]          shotlen;
  logic                 resetacc;
  logic                 trig;
  logic                 adc_valid;
  logic signed [DW-1:0] adc_data;
  logic                 stb_reset_bram_read;
  logic                 rd_stb;
  logic [ACCW-1:0]      rd_data;
  logic                 busy;
  logic [NSHOTW-1:0]    shotcnt;
  logic                 lastshotdone;
  logic [AW-1:0]        addr_accbuf_mon;

  modport master (
    output stb_start, nshot, shotlen, resetacc, trig, adc_valid, adc_data,
    output stb_reset_bram_read, rd_stb,
    input  rd_data, busy, shotcnt, lastshotdone, addr_accbuf_mon
  );

  modport slave (
    input  stb_start, nshot, shotlen, resetacc, trig, adc_valid, adc_data,
    input  stb_reset_bram_read, rd_stb,
    output rd_data, busy, shotcnt, lastshotdone, addr_accbuf_mon
  );

endinterface

// File: rtl/shot_acc_buf_acc_ram.sv
// Simple dual-port accumulation RAM: port A synchronous write,
// port B registered read with enable (output holds when not reading).
module acc_ram #(
  parameter int unsigned AW   = 10,
  parameter int unsigned ACCW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ACCW-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [ACCW-1:0] rdata
);

  logic [ACCW-1:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/shot_acc_buf.sv
// Shot sequencer and read-modify-write accumulation buffer (DSP clock domain).
// Sums shotlen ADC samples per triggered shot into acc_ram over nshot shots.
module shot_acc_buf
  import shot_acc_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 10,
  parameter int unsigned ACCW   = 32,
  parameter int unsigned NSHOTW = 16
) (
  input logic           clk,
  input logic           reset,
  shot_acc_buf_if.slave bus
);

  state_t            state;
  logic              busy_q;
  logic              lastshotdone_q;
  logic [NSHOTW-1:0] shotcnt_q;
  logic [NSHOTW-1:0] nshot_l;
  logic [AW:0]       shotlen_l;
  logic              resetacc_l;
  logic [AW-1:0]     a;
  logic [1:0]        flush_cnt;

  logic                 s0_valid;
  logic                 s0_ovw;
  logic [AW-1:0]        s0_addr;
  logic signed [DW-1:0] s0_sample;
  logic                 s1_valid;
  logic [AW-1:0]        s1_addr;
  logic [ACCW-1:0]      s1_data;

  logic [AW-1:0]   ptr;
  logic            rd_pend;
  logic [ACCW-1:0] rd_data_q;

  logic            acc_take;
  logic            host_rd;
  logic            ram_re;
  logic            ram_we;
  logic [AW-1:0]   ram_raddr;
  logic [ACCW-1:0] ram_rdata;
  logic [ACCW-1:0] wdata_nxt;
  logic [AW:0]     shotlen_clamp;

  // Port B is shared: the RMW read owns it in RUN, the host read only in IDLE.
  always_comb begin
    acc_take      = (state == RUN) && bus.adc_valid;
    host_rd       = (state == IDLE) && bus.rd_stb && !bus.stb_reset_bram_read;
    ram_re        = acc_take || host_rd;
    ram_raddr     = acc_take ? a : ptr;
    ram_we        = s1_valid && !reset;
    shotlen_clamp = bus.shotlen[AW] ? {1'b1, {AW{1'b0}}} : bus.shotlen;
  end

  always_comb begin
    wdata_nxt = s0_ovw ? ACCW'(s0_sample)
                       : ACCW'(sat_add(SAT_W'(signed'(ram_rdata)), SAT_W'(s0_sample), ACCW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy_q         <= 1'b0;
      lastshotdone_q <= 1'b0;
      shotcnt_q      <= '0;
      nshot_l        <= '0;
      shotlen_l      <= '0;
      resetacc_l     <= 1'b0;
      a              <= '0;
      flush_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.stb_start) begin
            nshot_l    <= bus.nshot;
            shotlen_l  <= shotlen_clamp;
            resetacc_l <= bus.resetacc;
            shotcnt_q  <= '0;
            if (bus.nshot == '0) begin
              lastshotdone_q <= 1'b1;
            end else begin
              lastshotdone_q <= 1'b0;
              busy_q         <= 1'b1;
              state          <= ARM;
            end
          end
        end
        ARM: begin
          if (bus.trig) begin
            a         <= '0;
            flush_cnt <= '0;
            state     <= (shotlen_l == '0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (bus.adc_valid) begin
            a <= a + 1'b1;
            if ({1'b0, a} == shotlen_l - 1'b1) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The last sample's write lands on the final flush cycle, so the
          // next shot's first read of address 0 always sees it.
          if (flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
            shotcnt_q <= shotcnt_q + 1'b1;
            if (shotcnt_q + 1'b1 == nshot_l) begin
              busy_q         <= 1'b0;
              lastshotdone_q <= 1'b1;
              state          <= IDLE;
            end else begin
              state <= ARM;
            end
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s0_valid <= acc_take;
      s1_valid <= s0_valid;
    end
  end

  always_ff @(posedge clk) begin
    s0_addr   <= a;
    s0_sample <= bus.adc_data;
    s0_ovw    <= resetacc_l && (shotcnt_q == '0);
    s1_addr   <= s0_addr;
    s1_data   <= wdata_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      rd_pend   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_pend <= host_rd;
      if (rd_pend) begin
        rd_data_q <= ram_rdata;
      end
      if (bus.stb_reset_bram_read) begin
        ptr <= '0;
      end else if (host_rd) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  acc_ram #(
    .AW   (AW),
    .ACCW (ACCW)
  ) u_acc_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (s1_addr),
    .wdata (s1_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // rd_data follows the RAM output register for the cycle after a host read, then holds.
  assign bus.rd_data         = rd_pend ? ram_rdata : rd_data_q;
  assign bus.busy            = busy_q;
  assign bus.shotcnt         = shotcnt_q;
  assign bus.lastshotdone    = lastshotdone_q;
  assign bus.addr_accbuf_mon = busy_q ? s1_addr : ptr;

endmodule

// File: tb/tb_shot_acc_buf.sv
// Scoreboard bench for shot_acc_buf: stimulus pushes expected readback words
// and run-end status; a negedge monitor pops and compares them.
module tb_shot_acc_buf;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 10;
  localparam int unsigned ACCW   = 20;
  localparam int unsigned NSHOTW = 16;

  logic clk;
  logic reset;

  shot_acc_buf_if #(.DW(DW), .AW(AW), .ACCW(ACCW), .NSHOTW(NSHOTW)) bus ();

  shot_acc_buf #(.DW(DW), .AW(AW), .ACCW(ACCW), .NSHOTW(NSHOTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    bit lsd;
  } run_exp_t;

  int       rd_q[$];
  run_exp_t run_q[$];
  int       errors;
  int       checks;
  int       svals[8];
  int       race_at;
  logic     rd_issued;
  logic     prev_busy;
  int       mon_e;
  run_exp_t mon_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    rd_issued <= bus.rd_stb && !bus.stb_reset_bram_read && !bus.busy && !reset;
  end

  always @(negedge clk) begin
    if (rd_issued === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: unexpected read return %0d, none expected", $signed(bus.rd_data));
      end else begin
        mon_e = rd_q.pop_front();
        if (int'($signed(bus.rd_data)) != mon_e) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d", $signed(bus.rd_data), mon_e);
        end
      end
    end
    if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
      checks++;
      if (run_q.size() == 0) begin
        errors++;
        $display("FAIL run_end: unexpected end of run, shotcnt=%0d", bus.shotcnt);
      end else begin
        mon_r = run_q.pop_front();
        if (int'(bus.shotcnt) != mon_r.cnt) begin
          errors++;
          $display("FAIL run_end shotcnt: got %0d expected %0d", bus.shotcnt, mon_r.cnt);
        end
        checks++;
        if (bus.lastshotdone != mon_r.lsd) begin
          errors++;
          $display("FAIL run_end lastshotdone: got %0d expected %0d", bus.lastshotdone, mon_r.lsd);
        end
      end
    end
    prev_busy <= bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_run(input int ns, input int sl, input bit racc);
    bus.nshot     = NSHOTW'(ns);
    bus.shotlen   = (AW+1)'(sl);
    bus.resetacc  = racc;
    bus.stb_start = 1'b1;
    tick();
    bus.stb_start = 1'b0;
  endtask

  task automatic expect_run(input int cnt, input bit lsd);
    run_exp_t r;
    r.cnt = cnt;
    r.lsd = lsd;
    run_q.push_back(r);
  endtask

  // One triggered shot of n samples from svals; with gaps, a stall cycle
  // carrying a stray trig precedes every sample after the first.
  task automatic shot(input int n, input bit gaps);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        bus.adc_valid = 1'b0;
        bus.trig      = 1'b1;
        tick();
        bus.trig = 1'b0;
      end
      bus.stb_start = (i == race_at);
      bus.adc_valid = 1'b1;
      bus.adc_data  = DW'(svals[i]);
      tick();
    end
    bus.stb_start = 1'b0;
    bus.adc_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic shot_const(input int n, input int v, input bit gaps);
    for (int i = 0; i < 8; i++) svals[i] = v;
    shot(n, gaps);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0d after %0d cycles, required 0", bus.busy, k);
    end
  endtask

  task automatic rd_ptr_reset();
    bus.stb_reset_bram_read = 1'b1;
    tick();
    bus.stb_reset_bram_read = 1'b0;
  endtask

  task automatic rd_one(input int e);
    rd_q.push_back(e);
    bus.rd_stb = 1'b1;
    tick();
  endtask

  task automatic rd_end();
    bus.rd_stb = 1'b0;
    tick();
  endtask

  initial begin
    race_at                 = -1;
    reset                   = 1'b1;
    bus.stb_start           = 1'b0;
    bus.nshot               = '0;
    bus.shotlen             = '0;
    bus.resetacc            = 1'b0;
    bus.trig                = 1'b0;
    bus.adc_valid           = 1'b0;
    bus.adc_data            = '0;
    bus.stb_reset_bram_read = 1'b0;
    bus.rd_stb              = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset busy", longint'(bus.busy), 0);
    check("reset shotcnt", longint'(bus.shotcnt), 0);
    check("reset lastshotdone", longint'(bus.lastshotdone), 0);
    check("reset addr_mon", longint'(bus.addr_accbuf_mon), 0);
    check("reset rd_data", longint'(bus.rd_data), 0);

    // Overwrite: one shot of 1,2,3,4
    start_run(1, 4, 1'b1);
    expect_run(1, 1'b1);
    svals = '{1, 2, 3, 4, 0, 0, 0, 0};
    shot(4, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(1); rd_one(2); rd_one(3); rd_one(4);
    rd_end();

    // Accumulate 3 x -5, with host reads and a start strobe issued mid-run
    start_run(3, 8, 1'b1);
    expect_run(3, 1'b1);
    bus.rd_stb = 1'b1;
    tick();
    tick();
    bus.rd_stb = 1'b0;
    check("rd_data hold while busy", longint'($signed(bus.rd_data)), 4);
    bus.nshot = NSHOTW'(1);
    race_at   = 3;
    shot_const(8, -5, 1'b0);
    race_at = -1;
    check("shotcnt after start race", longint'(bus.shotcnt), 1);
    shot_const(8, -5, 1'b0);
    shot_const(8, -5, 1'b0);
    wait_idle();
    rd_ptr_reset();
    for (int i = 0; i < 8; i++) rd_one(-15);
    rd_end();

    // Follow-up accumulate without overwrite, with adc_valid gaps
    start_run(1, 8, 1'b0);
    expect_run(1, 1'b1);
    shot_const(8, -5, 1'b1);
    wait_idle();
    rd_ptr_reset();
    for (int i = 0; i < 5; i++) rd_one(-20);
    rd_end();
    check("addr_mon after 5 reads", longint'(bus.addr_accbuf_mon), 5);

    // Positive and negative saturation at 20 bits
    start_run(20, 2, 1'b1);
    expect_run(20, 1'b1);
    repeat (20) shot_const(2, 32767, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(524287); rd_one(524287);
    rd_end();
    start_run(20, 2, 1'b1);
    expect_run(20, 1'b1);
    repeat (20) shot_const(2, -32768, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(-524288); rd_one(-524288);
    rd_end();

    // Reset in the middle of RUN
    start_run(2, 4, 1'b1);
    bus.trig = 1'b1;
    tick();
    bus.trig      = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data  = DW'(100);
    tick();
    tick();
    bus.adc_valid = 1'b0;
    expect_run(0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid-run reset shotcnt", longint'(bus.shotcnt), 0);
    check("mid-run reset lastshotdone", longint'(bus.lastshotdone), 0);
    check("mid-run reset busy", longint'(bus.busy), 0);

    // nshot == 0 completes immediately without going busy
    start_run(0, 4, 1'b1);
    check("nshot0 lastshotdone", longint'(bus.lastshotdone), 1);
    check("nshot0 busy", longint'(bus.busy), 0);
    tick();
    check("nshot0 busy later", longint'(bus.busy), 0);

    // Run after reset is clean
    start_run(1, 4, 1'b1);
    expect_run(1, 1'b1);
    svals = '{10, 20, 30, 40, 0, 0, 0, 0};
    shot(4, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(10); rd_one(20); rd_one(30); rd_one(40);
    rd_end();

    // shotlen == 0 leaves the buffer untouched
    start_run(2, 0, 1'b1);
    expect_run(2, 1'b1);
    shot(0, 1'b0);
    shot(0, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(10); rd_one(20);
    rd_end();

    // shotlen == 1 with back-to-back triggers: 7 + 9 + 11
    start_run(3, 1, 1'b1);
    expect_run(3, 1'b1);
    svals[0] = 7;
    shot(1, 1'b0);
    svals[0] = 9;
    shot(1, 1'b0);
    svals[0] = 11;
    shot(1, 1'b0);
    wait_idle();
    rd_ptr_reset();
    rd_one(27); rd_one(20);
    rd_end();

    tick();
    check("scoreboard drained", longint'(rd_q.size() + run_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shot_acc_buf.md
Name: shot_acc_buf

Overview:
- DSP-clock-domain shot sequencer and accumulation buffer.
- Directly consumes the per-channel ADC sample stream and the run-control strobes delivered on the DSP interface: start strobe, shot count, accumulate-reset and BRAM-read-pointer reset.
- Sums SHOTLEN samples per shot into an on-chip buffer over nshot triggered shots.
- Returns shot count, last-shot-done and an address monitor to the DSP register bank; exposes a host readback port.

Parameters:
- DW, 16, ADC sample width (signed)
- AW, 10, buffer address width; depth 2^AW
- ACCW, 32, accumulator word width (signed), ACCW > DW
- NSHOTW, 16, width of nshot/shotcnt

Ports:
- clk  in  1  DSP clock
- reset  in  1  synchronous, active-high
- stb_start  in  1  one-cycle run start strobe
- nshot  in  NSHOTW  shots per run, sampled at start
- shotlen  in  AW+1  samples per shot, sampled at start
- resetacc  in  1  1 = first shot overwrites buffer; sampled at start
- trig  in  1  shot trigger pulse
- adc_valid  in  1  sample qualifier
- adc_data  in  DW  signed sample
- stb_reset_bram_read  in  1  clears the host read pointer
- rd_stb  in  1  host read: present word at pointer, then post-increment
- rd_data  out  ACCW  buffer word, registered
- busy  out  1  run in progress
- shotcnt  out  NSHOTW  completed shots in the current/last run
- lastshotdone  out  1  sticky run-complete flag
- addr_accbuf_mon  out  AW  current write address (accumulate or readback)

Behaviour:
- Reset: state IDLE; busy=0, shotcnt=0, lastshotdone=0, addr_accbuf_mon=0, rd_data=0, read pointer=0. Buffer contents are not cleared.
- States: IDLE, ARM, RUN, FLUSH.
- IDLE:
  - On stb_start, latch nshot, shotlen (clamped to 2^AW) and resetacc.
  - Clear shotcnt and lastshotdone; set busy=1.
  - If nshot==0: stay IDLE, busy stays 0, lastshotdone=1 next cycle. Otherwise go to ARM.
- ARM: wait for trig; on trig go to RUN with sample address 0. If latched shotlen==0, go straight to FLUSH.
- RUN:
  - Each adc_valid cycle accepts one sample at address a, then a increments.
  - Cycles without adc_valid stall; trig is ignored.
  - After the sample at shotlen-1, go to FLUSH.
- FLUSH:
  - Fixed 2 cycles to drain the read-modify-write pipeline, which guarantees no RAW hazard on the next shot's address 0.
  - Then shotcnt++.
  - If shotcnt == nshot: go to IDLE, busy=0, lastshotdone=1. Otherwise go to ARM.
- Accumulate pipeline (RAM read latency 1):
  - c0: issue read at a, register sample and a.
  - c1: sum = rdata + sign-extended sample, saturating at the signed ACCW limits.
  - c2: write.
  - On the first shot with latched resetacc=1, the write value is the sign-extended sample (no add).
- stb_start while busy is ignored.
- lastshotdone stays high until the next accepted stb_start.
- Reset mid-run: return to IDLE immediately. In-flight writes are dropped; partially written addresses keep whatever was written.
- Readback, valid only in IDLE:
  - The host read shares the RMW read port.
  - rd_stb presents buffer[ptr] on rd_data one cycle later, then ptr increments mod 2^AW.
  - stb_reset_bram_read sets ptr=0; if it coincides with rd_stb, reset wins.
  - rd_stb while busy is ignored and rd_data holds.
- addr_accbuf_mon shows the c2 write address while busy and ptr while idle.

Decomposition:
- Package shot_acc_pkg holds:
  - state enum (IDLE, ARM, RUN, FLUSH)
  - FLUSH_CYCLES=2 constant
  - saturating signed add function
- Sub-module acc_ram: simple dual-port RAM, 2^AW x ACCW, sync write, registered read. Port B is muxed between the RMW pipeline and the host read.

Test Plan:
- Overwrite: reset, resetacc=1, nshot=1, shotlen=4, trig, samples 1,2,3,4 -> buffer[0..3]=1,2,3,4; shotcnt=1; lastshotdone=1; busy=0.
- Accumulate: nshot=3, resetacc=1, shotlen=8, constant sample -5 -> every word reads -15; shotcnt=3. A follow-up run with resetacc=0, nshot=1 -> -20.
- Saturation and sign: ACCW=20, DW=16, resetacc=1, nshot=20, sample 0x7FFF -> word=524287 (clamped). With sample 0x8000 -> -524288.
- Boundaries: nshot=0 -> lastshotdone=1 within 2 cycles, busy never 1. shotlen=0, nshot=2 -> shotcnt=2, buffer unchanged. shotlen=1 back-to-back triggers -> correct sums (no RAW hazard).
- Control races:
  - stb_start during RUN is ignored and shotcnt is unaffected.
  - adc_valid gaps stall addressing with no skipped addresses.
  - reset asserted mid-RUN -> IDLE, shotcnt=0, next run is correct.
- Readback: after run, stb_reset_bram_read then 5 rd_stb -> rd_data = buffer[0..4] at 1-cycle latency; addr_accbuf_mon=5. rd_stb while busy does not change rd_data.
